// File: rtl/rsa_pkg.sv
// Shared encodings and helpers for the runtime-keyed RSA modular-exponentiation engine.
package rsa_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_TO_MONT   = 3'd1;
    localparam state_t S_SQR       = 3'd2;
    localparam state_t S_MUL       = 3'd3;
    localparam state_t S_FROM_MONT = 3'd4;
    localparam state_t S_OUT       = 3'd5;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int calc_k(input int n_bit, input int logr);
        return n_bit / logr;
    endfunction

    function automatic bit digits_fit(input int n_bit, input int logr);
        return (n_bit % logr) == 0;
    endfunction

endpackage

// File: rtl/rsa_if.sv
// Host-side key, request and result signals of the modexp engine.
interface rsa_if #(
    parameter int N_BIT   = 12,
    parameter int LOGR    = 3,
    parameter int EXP_BIT = 12
);
    logic               key_load;
    logic [N_BIT-1:0]   key_n;
    logic [LOGR-1:0]    key_p;
    logic [N_BIT-1:0]   key_rmodn;
    logic [N_BIT-1:0]   key_r2modn;
    logic [EXP_BIT-1:0] key_e;
    logic [EXP_BIT-1:0] key_d;

    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [N_BIT-1:0]   in_data;

    logic               out_valid;
    logic               out_ready;
    logic [N_BIT-1:0]   out_data;
    logic               out_err;
    logic               busy;

    modport master (
        output key_load, key_n, key_p, key_rmodn, key_r2modn, key_e, key_d,
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

    modport slave (
        input  key_load, key_n, key_p, key_rmodn, key_r2modn, key_e, key_d,
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/mont_mul.sv
// Radix-2^LOGR Montgomery multiplier: result = a*b*R^-1 mod n, valid while done pulses.
module mont_mul
    import rsa_pkg::*;
#(
    parameter int N_BIT = 12,
    parameter int LOGR  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic [N_BIT-1:0] n,
    input  logic [LOGR-1:0]  p,
    output logic [N_BIT-1:0] result,
    output logic             done
);
    localparam int K  = calc_k(N_BIT, LOGR);
    localparam int TW = N_BIT + LOGR + 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (!digits_fit(N_BIT, LOGR)) begin : g_bad_radix
        $error("mont_mul: N_BIT must be a multiple of LOGR");
    end

    logic [N_BIT-1:0] a_q, b_q, n_q;
    logic [LOGR-1:0]  p_q;
    logic [TW-1:0]    t_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    logic [TW-1:0]    t_add, t_red;
    logic [LOGR-1:0]  q;

    always_comb begin
        t_add = t_q + TW'(a_q[LOGR-1:0]) * TW'(b_q);
        q     = t_add[LOGR-1:0] * p_q;
        t_red = (t_add + TW'(q) * TW'(n_q)) >> LOGR;
    end

    // T stays below 2n, so one conditional subtract finishes the reduction.
    assign result = (t_q >= TW'(n_q)) ? N_BIT'(t_q - TW'(n_q)) : t_q[N_BIT-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            p_q   <= '0;
            t_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q   <= a;
                b_q   <= b;
                n_q   <= n;
                p_q   <= p;
                t_q   <= '0;
                cnt_q <= CW'(K - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                t_q <= t_red;
                a_q <= a_q >> LOGR;
                if (cnt_q == '0) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/rsa_modexp_core.sv
// Runtime-keyed RSA modexp engine: left-to-right square-and-multiply in the Montgomery domain.
//   state       | meaning
//   IDLE        | in_ready high; key writes and requests accepted
//   TO_MONT     | xm = MM(x, R^2 mod n)
//   SQR         | acc = MM(acc, acc) for the current exponent bit
//   MUL         | acc = MM(acc, xm), kept only when the bit is 1
//   FROM_MONT   | result = MM(acc, 1)
//   OUT         | out_valid held until out_ready
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int N_BIT      = 12,
    parameter int LOGR       = 3,
    parameter int EXP_BIT    = 12,
    parameter int CONST_TIME = 0,
    parameter int N_DEF      = 3551,
    parameter int P_DEF      = 1,
    parameter int RMODN_DEF  = 545,
    parameter int R2MODN_DEF = 2292,
    parameter int E_DEF      = 5,
    parameter int D_DEF      = 1373
) (
    input  logic clk,
    input  logic rst_n,
    rsa_if.slave bus
);
    localparam int BW = (EXP_BIT > 1) ? $clog2(EXP_BIT) : 1;

    state_t             state_q;
    logic [N_BIT-1:0]   n_q, rmodn_q, r2modn_q;
    logic [LOGR-1:0]    p_q;
    logic [EXP_BIT-1:0] e_q, d_q, exp_q;
    logic [N_BIT-1:0]   x_q, xm_q, acc_q, out_data_q;
    logic [BW-1:0]      bit_cnt_q;
    logic               issued_q, out_valid_q, out_err_q;

    logic               key_we, accept, compute, mm_start, mm_done, bit_now, last_bit;
    logic [N_BIT-1:0]   n_eff, mm_a, mm_b, mm_res;
    logic [EXP_BIT-1:0] exp_sel;

    assign compute  = state_q inside {S_TO_MONT, S_SQR, S_MUL, S_FROM_MONT};
    assign key_we   = bus.key_load && (state_q == S_IDLE) && !out_valid_q;
    assign accept   = bus.in_valid && (state_q == S_IDLE);
    assign mm_start = compute && !issued_q;
    assign bit_now  = exp_q[EXP_BIT-1];
    assign last_bit = (bit_cnt_q == '0);

    // A key written in the accept cycle applies to that same request.
    assign n_eff   = key_we ? bus.key_n : n_q;
    assign exp_sel = (bus.in_mode == MODE_DEC) ? (key_we ? bus.key_d : d_q)
                                               : (key_we ? bus.key_e : e_q);

    always_comb begin
        mm_a = acc_q;
        mm_b = acc_q;
        case (state_q)
            S_TO_MONT:   begin mm_a = x_q; mm_b = r2modn_q; end
            S_MUL:       mm_b = xm_q;
            S_FROM_MONT: mm_b = N_BIT'(1);
            default:     begin end
        endcase
    end

    mont_mul #(.N_BIT(N_BIT), .LOGR(LOGR)) u_mm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .n      (n_q),
        .p      (p_q),
        .result (mm_res),
        .done   (mm_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= N_BIT'(N_DEF);
            p_q         <= LOGR'(P_DEF);
            rmodn_q     <= N_BIT'(RMODN_DEF);
            r2modn_q    <= N_BIT'(R2MODN_DEF);
            e_q         <= EXP_BIT'(E_DEF);
            d_q         <= EXP_BIT'(D_DEF);
            exp_q       <= '0;
            x_q         <= '0;
            xm_q        <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            issued_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (key_we) begin
                n_q      <= bus.key_n;
                p_q      <= bus.key_p;
                rmodn_q  <= bus.key_rmodn;
                r2modn_q <= bus.key_r2modn;
                e_q      <= bus.key_e;
                d_q      <= bus.key_d;
            end
            if (mm_start) issued_q <= 1'b1;
            if (mm_done)  issued_q <= 1'b0;

            case (state_q)
                S_IDLE: if (accept) begin
                    x_q       <= bus.in_data;
                    exp_q     <= exp_sel;
                    acc_q     <= key_we ? bus.key_rmodn : rmodn_q;
                    bit_cnt_q <= BW'(EXP_BIT - 1);
                    if (bus.in_data >= n_eff) begin
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        out_data_q  <= '0;
                        state_q     <= S_OUT;
                    end else begin
                        state_q <= S_TO_MONT;
                    end
                end
                S_TO_MONT: if (mm_done) begin
                    xm_q    <= mm_res;
                    state_q <= S_SQR;
                end
                S_SQR: if (mm_done) begin
                    acc_q <= mm_res;
                    if (CONST_TIME != 0 || bit_now) begin
                        state_q <= S_MUL;
                    end else if (last_bit) begin
                        state_q <= S_FROM_MONT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - BW'(1);
                        exp_q     <= exp_q << 1;
                    end
                end
                S_MUL: if (mm_done) begin
                    if (bit_now) acc_q <= mm_res;
                    if (last_bit) begin
                        state_q <= S_FROM_MONT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - BW'(1);
                        exp_q     <= exp_q << 1;
                        state_q   <= S_SQR;
                    end
                end
                S_FROM_MONT: if (mm_done) begin
                    out_data_q  <= mm_res;
                    out_err_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = compute;
endmodule
